// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
//   Frames start/data/stop bits from a strobed serial input, assembles WIDTH-bit words
//   LSB-first and presents them through a one-word valid/ready holding register.
//   Framing errors and overruns are flagged with one-cycle pulses and counted.
// Ports
//   i_clk        clock, all logic on posedge
//   i_rst        synchronous active-high reset
//   i_din        serial bit
//   i_din_en     i_din carries a valid bit this cycle
//   i_out_ready  consumer accepts o_out_data this cycle
//   o_out_data   assembled word, LSB = first data bit received
//   o_out_valid  o_out_data holds an unconsumed word
//   o_frame_err  one-cycle pulse: bad stop bit, word discarded
//   o_overrun    one-cycle pulse: good word discarded, holding register full
//   o_drop_cnt   saturating count of frame errors plus overruns
module serial_word_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter logic        START_VAL = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_din,
  input  logic             i_din_en,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_drop_cnt
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

  state_e           r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_shreg, w_shreg_next;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic             r_valid, w_valid_next;
  logic             r_ferr, r_ovr;
  logic [CNT_W-1:0] r_drop, w_drop_next;
  logic             w_good, w_ferr, w_ovr, w_load;

  // Framing FSM: only advances on strobed bits
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shreg_next = r_shreg;
    w_good       = 1'b0;
    w_ferr       = 1'b0;
    if (i_din_en) begin
      unique case (r_state)
        StIdle: begin
          if (i_din == START_VAL) begin
            w_state_next = StData;
            w_cnt_next   = '0;
          end
        end
        StData: begin
          w_shreg_next = {i_din, r_shreg[WIDTH-1:1]};
          w_cnt_next   = r_cnt + 1'b1;
          if (r_cnt == LastBit) w_state_next = StStop;
        end
        StStop: begin
          if (i_din != START_VAL) w_good = 1'b1;
          else                    w_ferr = 1'b1;
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Holding register: a load may coincide with a drain, keeping valid high
  always_comb begin
    w_load       = w_good && (!r_valid || i_out_ready);
    w_ovr        = w_good && r_valid && !i_out_ready;
    w_data_next  = w_load ? r_shreg : r_data;
    w_valid_next = r_valid;
    if (w_load)                      w_valid_next = 1'b1;
    else if (r_valid && i_out_ready) w_valid_next = 1'b0;
    w_drop_next = r_drop;
    if ((w_ferr || w_ovr) && (r_drop != '1)) w_drop_next = r_drop + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shreg <= w_shreg_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_ferr  <= w_ferr;
      r_ovr   <= w_ovr;
      r_drop  <= w_drop_next;
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_frame_err = r_ferr;
  assign o_overrun   = r_ovr;
  assign o_drop_cnt  = r_drop;

endmodule
